vic_irq_arbiter: RTL

Vectored IRQ priority arbiter and hardware priority-nesting sequencer for the VIC.
- Takes the masked IRQ status plus the 16 vector slot configurations (enable, source number, vector address) and the default vector address.
- Selects the highest-priority request not masked by an in-service interrupt, and drives nVICIRQ and the vector address.
- Tracks service start (CPU read of VectAddr) and service end (CPU write of VectAddr) to push and pop a priority level.
- Sits between the VIC register file and the CPU IRQ interface.

---
 rtl/vic_irq_arbiter_if.sv | 33 +++
 rtl/vic_irq_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/vic_irq_arbiter_if.sv
// Bus bundle between the VIC register file / CPU port and the IRQ arbiter.
// master = register-file side (drives config and VectAddr strobes), slave = arbiter.
interface vic_irq_arbiter_if #(
  parameter int NUM_SLOTS = 16,
  parameter int INTW      = 32,
  parameter int ADDR_W    = 32
);
  logic [INTW-1:0]             irq_status;
  logic [NUM_SLOTS-1:0]        slot_en;
  logic [NUM_SLOTS*5-1:0]      slot_src_flat;
  logic [NUM_SLOTS*ADDR_W-1:0] slot_addr_flat;
  logic [ADDR_W-1:0]           def_vect_addr;
  logic                        vaddr_rd;
  logic                        vaddr_wr;
  logic                        nVICIRQ;
  logic [ADDR_W-1:0]           vect_addr;
  logic [4:0]                  handler_num;
  logic                        handler_valid;
  logic [NUM_SLOTS:0]          in_service;
  logic                        rd_collide;

  modport master (
    output irq_status, slot_en, slot_src_flat, slot_addr_flat, def_vect_addr,
           vaddr_rd, vaddr_wr,
    input  nVICIRQ, vect_addr, handler_num, handler_valid, in_service, rd_collide
  );

  modport slave (
    input  irq_status, slot_en, slot_src_flat, slot_addr_flat, def_vect_addr,
           vaddr_rd, vaddr_wr,
    output nVICIRQ, vect_addr, handler_num, handler_valid, in_service, rd_collide
  );
endinterface

// File: rtl/vic_irq_arbiter.sv
// VIC vectored IRQ priority arbiter with in-service priority ceiling.
// VIC_NEST_EN: full nesting; undefined: only one level may be in service at a time.
module vic_slot_hit #(
  parameter int INTW = 32
) (
  input  logic            en,
  input  logic [4:0]      src,
  input  logic [INTW-1:0] irq_status,
  output logic            hit,
  output logic [INTW-1:0] vmask
);
  localparam logic [INTW-1:0] ONE = INTW'(1);

  assign hit   = en & irq_status[src];
  assign vmask = en ? (ONE << src) : '0;
endmodule

module vic_irq_arbiter #(
  parameter int NUM_SLOTS = 16,
  parameter int INTW      = 32,
  parameter int ADDR_W    = 32
) (
  input logic               clk,
  input logic               rst,
  vic_irq_arbiter_if.slave  bus
);
  localparam int LVLS = NUM_SLOTS + 1;
  localparam logic [LVLS-1:0] ONE_L = LVLS'(1);

  logic [NUM_SLOTS-1:0]            hit;
  logic [NUM_SLOTS-1:0][INTW-1:0]  vmask;
  logic [INTW-1:0]                 vec_mask;
  logic                            nv_hit;
  logic [LVLS-1:0]                 cand, elig;
  logic [4:0]                      ceil_lvl;
  logic                            found;
  logic [4:0]                      win;
  logic [ADDR_W-1:0]               win_addr;
  logic                            push;

  logic                handler_valid_d, handler_valid_q;
  logic [4:0]          handler_num_d, handler_num_q;
  logic [ADDR_W-1:0]   vect_addr_d, vect_addr_q;
  logic [LVLS-1:0]     in_service_d, in_service_q;
  logic                rd_collide_d, rd_collide_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    vic_slot_hit #(.INTW(INTW)) u_hit (
      .en         (bus.slot_en[g]),
      .src        (bus.slot_src_flat[5*g +: 5]),
      .irq_status (bus.irq_status),
      .hit        (hit[g]),
      .vmask      (vmask[g])
    );
  end

  // Sources claimed by any enabled slot never feed the default level.
  always_comb begin
    vec_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) vec_mask = vec_mask | vmask[i];
  end

  assign nv_hit = |(bus.irq_status & ~vec_mask);
  assign cand   = {nv_hit, hit};

  always_comb begin
`ifdef VIC_NEST_EN
    ceil_lvl = 5'(LVLS);
    for (int l = LVLS-1; l >= 0; l--) if (in_service_q[l]) ceil_lvl = 5'(l);
`else
    ceil_lvl = (|in_service_q) ? 5'd0 : 5'(LVLS);
`endif
    elig = '0;
    for (int l = 0; l < LVLS; l++) elig[l] = cand[l] && (l < int'(ceil_lvl));
  end

  // Descending scan so the lowest eligible level overwrites last.
  always_comb begin
    found    = elig[NUM_SLOTS];
    win      = found ? 5'(NUM_SLOTS) : 5'd0;
    win_addr = bus.def_vect_addr;
    for (int l = NUM_SLOTS-1; l >= 0; l--) begin
      if (elig[l]) begin
        found    = 1'b1;
        win      = 5'(l);
        win_addr = bus.slot_addr_flat[ADDR_W*l +: ADDR_W];
      end
    end
  end

  always_comb begin
    handler_valid_d = found;
    handler_num_d   = win;
    vect_addr_d     = win_addr;
    rd_collide_d    = bus.vaddr_rd & bus.vaddr_wr;
`ifdef VIC_NEST_EN
    push = bus.vaddr_rd & ~bus.vaddr_wr & handler_valid_q;
`else
    push = bus.vaddr_rd & ~bus.vaddr_wr & handler_valid_q & ~(|in_service_q);
`endif
    in_service_d = in_service_q;
    if (bus.vaddr_wr) begin
`ifdef VIC_NEST_EN
      in_service_d = in_service_q & (in_service_q - ONE_L);
`else
      in_service_d = '0;
`endif
    end else if (push) begin
      in_service_d[handler_num_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      handler_valid_q <= 1'b0;
      handler_num_q   <= '0;
      vect_addr_q     <= '0;
      in_service_q    <= '0;
      rd_collide_q    <= 1'b0;
    end else begin
      handler_valid_q <= handler_valid_d;
      handler_num_q   <= handler_num_d;
      vect_addr_q     <= vect_addr_d;
      in_service_q    <= in_service_d;
      rd_collide_q    <= rd_collide_d;
    end
  end

  assign bus.nVICIRQ       = ~handler_valid_q;
  assign bus.handler_valid = handler_valid_q;
  assign bus.handler_num   = handler_num_q;
  assign bus.vect_addr     = vect_addr_q;
  assign bus.in_service    = in_service_q;
  assign bus.rd_collide    = rd_collide_q;
endmodule
